pathfinder_wb_master: RTL and testbench

Wishbone classic-cycle initiator that turns single-word command/response handshakes into bus transactions toward the Pathfinder Wishbone slave port. It sits on the management/bring-up side of the user project: the Caravel harness bench, or an on-chip sequencer, issues a command and receives read data or an error. Each command produces exactly one bus cycle, and each bus cycle is bounded by a timeout. One transaction is outstanding at a time.

---
 rtl/pathfinder_wb_master.sv | 117 +++++++++++
 tb/tb_pathfinder_wb_master.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pathfinder_wb_master.sv
// Wishbone classic-cycle initiator: one command in, one bus cycle out, one response back.
// Ports: wb_clk_i/wb_rst_i, cmd_* request, rsp_* response, wbm_* bus, busy.
module pathfinder_wb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } state_t;

  localparam logic [15:0] LP_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_cnt;
  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic [31:0] r_rdata;
  logic        r_err;

  logic w_accept;
  logic w_ack;
  logic w_tmo;

  assign w_accept = (r_state == S_IDLE) & cmd_valid;
  assign w_ack    = (r_state == S_BUS) & wbm_ack_i;
  // ack wins over timeout on the same edge
  assign w_tmo    = (r_state == S_BUS) & ~wbm_ack_i & (r_cnt == LP_LAST);

  // cyc/stb derive from state so reset drops them without a clock edge
  assign cmd_ready = (r_state == S_IDLE) & ~wb_rst_i;
  assign rsp_valid = (r_state == S_RESP);
  assign busy      = (r_state != S_IDLE);
  assign wbm_cyc_o = (r_state == S_BUS);
  assign wbm_stb_o = (r_state == S_BUS);
  assign wbm_we_o  = r_we;
  assign wbm_sel_o = r_sel;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = S_BUS;
      S_BUS:  if (w_ack || w_tmo) w_next = S_RESP;
      S_RESP: if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt <= '0;
        r_we  <= cmd_we;
        r_sel <= cmd_sel;
        r_adr <= cmd_adr;
        r_dat <= cmd_dat;
      end
      if (w_ack) begin
        r_rdata <= r_we ? 32'h0 : wbm_dat_i;
        r_err   <= 1'b0;
      end else if (w_tmo) begin
        r_rdata <= r_we ? 32'h0 : ERR_DATA;
        r_err   <= 1'b1;
      end else if (r_state == S_BUS && r_cnt != 16'hFFFF) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pathfinder_wb_master.sv
// Directed self-checking bench for pathfinder_wb_master.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_pathfinder_wb_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        cyc;
  logic        stb;
  logic        we_o;
  logic [3:0]  sel_o;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic        ack;
  logic [31:0] dat_i;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int tick   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) tick <= tick + 1;

  pathfinder_wb_master #(
    .TIMEOUT_CYCLES(8),
    .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .cmd_sel  (cmd_sel),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .wbm_cyc_o(cyc),
    .wbm_stb_o(stb),
    .wbm_we_o (we_o),
    .wbm_sel_o(sel_o),
    .wbm_adr_o(adr_o),
    .wbm_dat_o(dat_o),
    .wbm_ack_i(ack),
    .wbm_dat_i(dat_i),
    .busy     (busy)
  );

  // Called on a falling edge in IDLE. ack_at=n acks in the n-th bus cycle,
  // 0 never acks. Returns the number of cycles cyc was high.
  task automatic bus_cmd(input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel,
                         input int ack_at, input logic [31:0] rd,
                         output int ncyc);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    @(negedge clk);
    cmd_valid = 1'b0;
    ncyc = 0;
    while (cyc && ncyc < 300) begin
      ncyc++;
      if (ncyc == ack_at) begin
        ack   = 1'b1;
        dat_i = rd;
      end
      @(negedge clk);
      ack   = 1'b0;
      dat_i = 32'h0;
    end
  endtask

  task automatic consume;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    checks++;
    if ({cyc, stb, we_o, sel_o, adr_o, dat_o, rsp_valid, rsp_rdata,
         rsp_err, busy, cmd_ready} !== '0) begin
      errors++;
      $display("FAIL rst_init: cyc=%b busy=%b rdy=%b adr=%h want all 0",
               cyc, busy, cmd_ready, adr_o);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_rdy: got %b want 1", cmd_ready);
    end
    // reset during BUS
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_adr   = 32'h3000_0040;
    cmd_dat   = 32'h5555_AAAA;
    cmd_sel   = 4'h3;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (cyc !== 1'b1 || adr_o !== 32'h3000_0040) begin
      errors++;
      $display("FAIL rst_bus_pre: cyc=%b adr=%h want 1 30000040", cyc, adr_o);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({cyc, stb, we_o, sel_o, adr_o, dat_o, rsp_valid, rsp_rdata,
         rsp_err, busy, cmd_ready} !== '0) begin
      errors++;
      $display("FAIL rst_bus: cyc=%b we=%b sel=%h adr=%h busy=%b want 0",
               cyc, we_o, sel_o, adr_o, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || cyc !== 1'b0) begin
        errors++;
        $display("FAIL rst_after: vld=%b rdy=%b cyc=%b want 0 1 0",
                 rsp_valid, cmd_ready, cyc);
      end
    end
    // reset during RESP discards the response
    bus_cmd(1'b0, 32'h3000_0008, 32'h0, 4'hF, 1, 32'h7777_8888, n);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h7777_8888) begin
      errors++;
      $display("FAIL rst_resp_pre: vld=%b data=%h want 1 77778888",
               rsp_valid, rsp_rdata);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_resp: vld=%b data=%h busy=%b want 0 0 0",
               rsp_valid, rsp_rdata, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write;
    int n;
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_adr   = 32'h3000_0004;
    cmd_dat   = 32'h1234_5678;
    cmd_sel   = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (cyc !== 1'b1 || stb !== 1'b1 || we_o !== 1'b1 ||
        adr_o !== 32'h3000_0004 || dat_o !== 32'h1234_5678 ||
        sel_o !== 4'hF || cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wr_bus: cyc=%b we=%b adr=%h dat=%h sel=%h rdy=%b",
               cyc, we_o, adr_o, dat_o, sel_o, cmd_ready);
    end
    ack   = 1'b1;
    dat_i = 32'hFFFF_FFFF;
    n = 1;
    @(negedge clk);
    ack = 1'b0;
    if (cyc) n++;
    checks++;
    if (n != 1 || rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 ||
        rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL wr_rsp: ncyc=%0d vld=%b data=%h err=%b want 1 1 0 0",
               n, rsp_valid, rsp_rdata, rsp_err);
    end
    consume();
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_idle: vld=%b rdy=%b want 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_read_wait;
    int n;
    bus_cmd(1'b0, 32'h3000_0000, 32'h0, 4'hF, 4, 32'hCAFE_F00D, n);
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL rd_ncyc: got %0d want 4", n);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_F00D ||
        rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL rd_rsp: vld=%b data=%h err=%b want 1 cafef00d 0",
               rsp_valid, rsp_rdata, rsp_err);
    end
    checks++;
    if (we_o !== 1'b0 || adr_o !== 32'h3000_0000) begin
      errors++;
      $display("FAIL rd_hold: we=%b adr=%h want 0 30000000", we_o, adr_o);
    end
    consume();
  endtask

  task automatic test_timeout;
    int n;
    bus_cmd(1'b0, 32'h3000_0100, 32'h0, 4'hF, 0, 32'h0, n);
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL to_ncyc: got %0d want 8", n);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 ||
        rsp_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL to_rsp: vld=%b err=%b data=%h want 1 1 deadbeef",
               rsp_valid, rsp_err, rsp_rdata);
    end
    consume();
    bus_cmd(1'b1, 32'h3000_0104, 32'h1, 4'h1, 0, 32'h0, n);
    checks++;
    if (n != 8 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL to_wr: ncyc=%0d err=%b data=%h want 8 1 0",
               n, rsp_err, rsp_rdata);
    end
    consume();
    bus_cmd(1'b0, 32'h3000_000C, 32'h0, 4'hF, 2, 32'h0BAD_CAFE, n);
    checks++;
    if (n != 2 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0BAD_CAFE) begin
      errors++;
      $display("FAIL to_next: ncyc=%0d err=%b data=%h want 2 0 0badcafe",
               n, rsp_err, rsp_rdata);
    end
    consume();
  endtask

  task automatic test_backpressure;
    int n;
    bus_cmd(1'b0, 32'h3000_0020, 32'h0, 4'hF, 1, 32'hA5A5_0001, n);
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_adr   = 32'h3000_0024;
    for (int i = 0; i < 10; i++) begin
      ack   = i[0];
      dat_i = 32'h1000 + i;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A5_0001 ||
          rsp_err !== 1'b0 || cyc !== 1'b0 || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_%0d: vld=%b data=%h cyc=%b rdy=%b", i,
                 rsp_valid, rsp_rdata, cyc, cmd_ready);
      end
    end
    ack   = 1'b0;
    dat_i = 32'h0;
    consume();
    checks++;
    if (cyc !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: cyc=%b rdy=%b vld=%b want 0 1 0",
               cyc, cmd_ready, rsp_valid);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int t[4];
    int w;
    logic [31:0] exp;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1;
      cmd_we    = (i == 2);
      cmd_adr   = 32'h3000_0010 + 32'(4 * i);
      cmd_dat   = 32'h2222_0000 + 32'(i);
      cmd_sel   = 4'hF;
      w = 0;
      while (!cmd_ready && w < 10) begin
        @(negedge clk);
        w++;
      end
      t[i] = tick;
      @(negedge clk);
      checks++;
      if (cyc !== 1'b1 || adr_o !== 32'h3000_0010 + 32'(4 * i)) begin
        errors++;
        $display("FAIL b2b_bus%0d: cyc=%b adr=%h", i, cyc, adr_o);
      end
      ack   = 1'b1;
      dat_i = 32'h1111_0000 + 32'(i);
      @(negedge clk);
      ack   = 1'b0;
      dat_i = 32'h0;
      exp = (i == 2) ? 32'h0 : 32'h1111_0000 + 32'(i);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp || rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL b2b_rsp%0d: vld=%b data=%h want 1 %h",
                 i, rsp_valid, rsp_rdata, exp);
      end
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (t[i] - t[i-1] != 3) begin
        errors++;
        $display("FAIL b2b_gap%0d: got %0d want 3", i, t[i] - t[i-1]);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = 32'h0;
    cmd_dat   = 32'h0;
    cmd_sel   = 4'h0;
    rsp_ready = 1'b0;
    ack       = 1'b0;
    dat_i     = 32'h0;
    #2;
    test_reset();
    test_write();
    test_read_wait();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
